dispatch_ctrl: RTL and testbench
================================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have parameter IBUF_DEPTH, default 4 (power of two, >=2): instruction-buffer entries.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- if_valid_i  in  1  fetch presents an instruction
- if_IR_i  in  32  fetched instruction
- if_npc_i  in  64  fetched instruction NPC
- if_stall_o  out  1  fetch must hold
- id_IR_o  out  32  head instruction to decoder
- id_npc_o  out  64  head NPC
- id_valid_inst_o  out  1  head entry valid
- id_rd_mem_i, id_wr_mem_i  in  1 each  decoder flags for the head
- id_halt_i, id_illegal_i  in  1 each  decoder flags for the head
- rob_full_i, rs_full_i, lsq_full_i  in  1 each  back-end structural full flags
- br_recover_i  in  1  mispredict flush
- rob_halt_retired_i  in  1  halt/illegal instruction committed
- dispatch_en_o  out  1  head dispatched this cycle
- halted_o  out  1  processor halted
- illegal_o  out  1  halt cause was illegal instruction

Function
REQ-003 SHALL keep a circular FIFO of IBUF_DEPTH entries {IR, NPC}, with head/tail pointers of log2(IBUF_DEPTH) bits that wrap modulo IBUF_DEPTH, and a count of log2(IBUF_DEPTH)+1 bits.
REQ-004 SHALL enqueue if_IR_i/if_npc_i at the posedge when if_valid_i=1, if_stall_o=0, and br_recover_i=0.
REQ-005 SHALL make enqueue-to-id_valid_inst_o latency exactly 1 cycle, with no same-cycle bypass.
REQ-006 SHALL drive id_IR_o/id_npc_o from the head entry and id_valid_inst_o = (count!=0) & (state==RUN).
REQ-007 SHALL assert dispatch_en_o = id_valid_inst_o & ~rob_full_i & ~rs_full_i & ~((id_rd_mem_i|id_wr_mem_i) & lsq_full_i) & ~br_recover_i.
REQ-008 SHALL dequeue the head at the posedge where dispatch_en_o=1.
REQ-009 SHALL assert if_stall_o = (count==IBUF_DEPTH) | (state!=RUN), derived from registered state only, with no combinational path from dispatch_en_o.
REQ-010 SHALL perform enqueue and dequeue together when both qualify (count unchanged); a full buffer accepts no enqueue even while dispatching.
REQ-011 SHALL implement an FSM with states RUN, HALT_PEND, HALTED.
REQ-012 SHALL move RUN->HALT_PEND when dispatch_en_o=1 and (id_halt_i|id_illegal_i); illegal_o SHALL capture id_illegal_i at that edge.
REQ-013 SHALL, in HALT_PEND, accept no enqueue, dispatch nothing, and retain buffer contents.
REQ-014 SHALL move HALT_PEND->HALTED on rob_halt_retired_i=1; HALTED is terminal until reset; halted_o=1 only in HALTED.
REQ-015 SHALL, on br_recover_i=1: reset head, tail, and count to 0; move HALT_PEND->RUN and clear illegal_o; leave HALTED unchanged.
REQ-016 SHALL give br_recover_i priority over simultaneous enqueue, dequeue, halt detection, and rob_halt_retired_i (recover wins in HALT_PEND).
REQ-017 SHALL ignore rob_halt_retired_i in RUN and HALTED.

Reset
REQ-018 SHALL, with rst=0, asynchronously set: state=RUN, head=tail=count=0, illegal_o=0.
REQ-019 SHALL, during reset, drive if_stall_o=0, id_valid_inst_o=0, dispatch_en_o=0, halted_o=0; id_IR_o/id_npc_o are don't-care while id_valid_inst_o=0.
REQ-020 SHALL not require reset on buffer data storage.

Configuration
REQ-021 SHALL, when DISPATCH_PERF_EN is defined, add outputs perf_stall_cnt_o[31:0] and perf_disp_cnt_o[31:0], both reset to 0:
- stall count increments each cycle id_valid_inst_o=1 & dispatch_en_o=0
- dispatch count increments on each dispatch_en_o=1
- both saturate at 32'hFFFF_FFFF and are not cleared by br_recover_i
REQ-022 SHALL, without DISPATCH_PERF_EN, have neither these ports nor their logic.

Structure
REQ-023 SHALL place the dispatch_state_t enum (RUN, HALT_PEND, HALTED) and the IBUF_DEPTH default in the shared sys_defs package.
REQ-024 SHALL contain one sub-module, dispatch_ibuf (FIFO storage and pointers); the FSM and stall logic live in dispatch_ctrl.

Verification
REQ-025 Fill: 4 back-to-back fetches with rob_full_i=1 -> count=4; if_stall_o=1 the cycle after the 4th enqueue; 5th instruction not captured.
REQ-026 Stream: continuous fetch, all full flags 0 -> dispatch_en_o=1 every cycle from cycle 2; count stays 1; IR order preserved across pointer wrap (>=10 instructions).
REQ-027 LSQ gating: head has id_rd_mem_i=1, lsq_full_i=1, rob_full_i=0 -> dispatch_en_o=0; same with id_rd_mem_i=0 -> dispatch_en_o=1.
REQ-028 Halt: dispatch halt (id_halt_i=1) -> HALT_PEND next cycle, if_stall_o=1, id_valid_inst_o=0; rob_halt_retired_i pulse -> halted_o=1 next cycle and stays 1.
REQ-029 Recover: count=3 in HALT_PEND with illegal_o=1; br_recover_i together with if_valid_i=1 -> count=0, state=RUN, illegal_o=0; no enqueue that cycle.
REQ-030 Reset mid-operation: rst low asynchronously with count=2 -> outputs reach REQ-019 values before the next clk edge; with DISPATCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/sys_defs.sv
`default_nettype none
// ============================================================================
// Module      : sys_defs (package)
// Description : Shared types and defaults for the dispatch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_defs;

    localparam int c_ibuf_depth = 4;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } dispatch_state_t;

    // A head that touches memory needs an LSQ slot to dispatch.
    function automatic logic is_mem_op(input logic rd_mem, input logic wr_mem);
        return rd_mem | wr_mem;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl_if
// Description : Fetch / decode / back-end handshake bundle for dispatch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface dispatch_ctrl_if;

    logic        if_valid_i;
    logic [31:0] if_IR_i;
    logic [63:0] if_npc_i;
    logic        if_stall_o;
    logic [31:0] id_IR_o;
    logic [63:0] id_npc_o;
    logic        id_valid_inst_o;
    logic        id_rd_mem_i;
    logic        id_wr_mem_i;
    logic        id_halt_i;
    logic        id_illegal_i;
    logic        rob_full_i;
    logic        rs_full_i;
    logic        lsq_full_i;
    logic        br_recover_i;
    logic        rob_halt_retired_i;
    logic        dispatch_en_o;
    logic        halted_o;
    logic        illegal_o;

    modport master (
        output if_valid_i, if_IR_i, if_npc_i,
        output id_rd_mem_i, id_wr_mem_i, id_halt_i, id_illegal_i,
        output rob_full_i, rs_full_i, lsq_full_i,
        output br_recover_i, rob_halt_retired_i,
        input  if_stall_o, id_IR_o, id_npc_o, id_valid_inst_o,
        input  dispatch_en_o, halted_o, illegal_o
    );

    modport slave (
        input  if_valid_i, if_IR_i, if_npc_i,
        input  id_rd_mem_i, id_wr_mem_i, id_halt_i, id_illegal_i,
        input  rob_full_i, rs_full_i, lsq_full_i,
        input  br_recover_i, rob_halt_retired_i,
        output if_stall_o, id_IR_o, id_npc_o, id_valid_inst_o,
        output dispatch_en_o, halted_o, illegal_o
    );

endinterface
`default_nettype wire

// File: rtl/dispatch_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ibuf
// Description : Circular instruction buffer {IR, NPC} with head/tail/count.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_ibuf
    import sys_defs::*;
#(
    parameter int IBUF_DEPTH = c_ibuf_depth
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_push,
    input  wire logic                          i_pop,
    input  wire logic                          i_flush,
    input  wire logic [31:0]                   i_wr_ir,
    input  wire logic [63:0]                   i_wr_npc,
    output      logic [31:0]                   o_head_ir,
    output      logic [63:0]                   o_head_npc,
    output      logic [$clog2(IBUF_DEPTH):0]   o_count,
    output      logic                          o_full,
    output      logic                          o_empty
);

    localparam int c_ptr_w = $clog2(IBUF_DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
    localparam logic [c_ptr_w:0]   c_cnt_one = 1;
    localparam logic [c_ptr_w:0]   c_cnt_max = (c_ptr_w+1)'(IBUF_DEPTH);

    logic [31:0]        r_ir_mem  [IBUF_DEPTH];
    logic [63:0]        r_npc_mem [IBUF_DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_cnt_max);
    assign o_empty = (r_count == '0);

    // Flush outranks both pointer moves; full/empty guard keeps count in range.
    assign w_push = i_push & ~o_full  & ~i_flush;
    assign w_pop  = i_pop  & ~o_empty & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ir_mem[r_tail]  <= i_wr_ir;
            r_npc_mem[r_tail] <= i_wr_npc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + c_ptr_one;
            if (w_pop)  r_head <= r_head + c_ptr_one;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_ir  = r_ir_mem[r_head];
    assign o_head_npc = r_npc_mem[r_head];
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl
// Description : Instruction buffer, dispatch gating and halt FSM.
//               Optional DISPATCH_PERF_EN adds stall/dispatch counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_ctrl
    import sys_defs::*;
#(
    parameter int IBUF_DEPTH = c_ibuf_depth
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dispatch_ctrl_if.slave    bus
`ifdef DISPATCH_PERF_EN
    ,
    output      logic [31:0]  perf_stall_cnt_o,
    output      logic [31:0]  perf_disp_cnt_o
`endif
);

    dispatch_state_t               r_state;
    dispatch_state_t               w_state_nxt;
    logic                          r_illegal;
    logic                          w_illegal_nxt;
    logic [$clog2(IBUF_DEPTH):0]   w_count;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_stall;
    logic                          w_push;
    logic                          w_id_valid;
    logic                          w_dispatch_en;
    logic                          w_halt_seen;

    dispatch_ibuf #(
        .IBUF_DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_dispatch_en),
        .i_flush    (bus.br_recover_i),
        .i_wr_ir    (bus.if_IR_i),
        .i_wr_npc   (bus.if_npc_i),
        .o_head_ir  (bus.id_IR_o),
        .o_head_npc (bus.id_npc_o),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Stall depends only on registered state so fetch never waits on dispatch.
    assign w_stall    = w_full | (r_state != RUN);
    assign w_push     = bus.if_valid_i & ~w_stall & ~bus.br_recover_i;
    assign w_id_valid = ~w_empty & (r_state == RUN);

    assign w_dispatch_en = w_id_valid & ~bus.rob_full_i & ~bus.rs_full_i
                         & ~(is_mem_op(bus.id_rd_mem_i, bus.id_wr_mem_i) & bus.lsq_full_i)
                         & ~bus.br_recover_i;

    assign w_halt_seen = w_dispatch_en & (bus.id_halt_i | bus.id_illegal_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RUN;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_illegal_nxt = r_illegal;
        case (r_state)
            RUN: begin
                if (bus.br_recover_i) begin
                    w_illegal_nxt = 1'b0;
                end else if (w_halt_seen) begin
                    w_state_nxt   = HALT_PEND;
                    w_illegal_nxt = bus.id_illegal_i;
                end
            end
            HALT_PEND: begin
                // Mispredict means the halt was on a wrong path: resume.
                if (bus.br_recover_i) begin
                    w_state_nxt   = RUN;
                    w_illegal_nxt = 1'b0;
                end else if (bus.rob_halt_retired_i) begin
                    w_state_nxt   = HALTED;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt   = RUN;
                w_illegal_nxt = 1'b0;
            end
        endcase
    end

    assign bus.if_stall_o      = w_stall;
    assign bus.id_valid_inst_o = w_id_valid;
    assign bus.dispatch_en_o   = w_dispatch_en;
    assign bus.halted_o        = (r_state == HALTED);
    assign bus.illegal_o       = r_illegal;

`ifdef DISPATCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_disp_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_disp_cnt  <= '0;
        end else begin
            if (w_id_valid && !w_dispatch_en && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_dispatch_en && (r_disp_cnt != 32'hFFFF_FFFF))
                r_disp_cnt <= r_disp_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_disp_cnt_o  = r_disp_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_ctrl
// Description : Directed self-checking bench for dispatch_ctrl (DISPATCH_PERF_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    dispatch_ctrl_if bus ();

`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_disp_cnt;
`endif

    dispatch_ctrl #(.IBUF_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_disp_cnt_o  (perf_disp_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_valid_i = 0; bus.if_IR_i = '0; bus.if_npc_i = '0;
        bus.id_rd_mem_i = 0; bus.id_wr_mem_i = 0; bus.id_halt_i = 0; bus.id_illegal_i = 0;
        bus.rob_full_i = 0; bus.rs_full_i = 0; bus.lsq_full_i = 0;
        bus.br_recover_i = 0; bus.rob_halt_retired_i = 0;

        // Reset state
        @(negedge clk);
        check("rst_stall",  bus.if_stall_o, 0);
        check("rst_valid",  bus.id_valid_inst_o, 0);
        check("rst_disp",   bus.dispatch_en_o, 0);
        check("rst_halted", bus.halted_o, 0);
        check("rst_illeg",  bus.illegal_o, 0);
        step();
        rst = 1'b1;

        // Fill with back-end blocked
        bus.rob_full_i = 1;
        for (int k = 0; k < 4; k++) begin
            bus.if_valid_i = 1;
            bus.if_IR_i    = 32'h100 + k;
            bus.if_npc_i   = 64'h1000 + 4 * k;
            @(negedge clk);
            if (k == 0) begin
                check("fill_nobypass", bus.id_valid_inst_o, 0);
            end else begin
                check("fill_valid", bus.id_valid_inst_o, 1);
                check("fill_nodisp", bus.dispatch_en_o, 0);
            end
            step();
        end
        bus.if_IR_i = 32'h1FF;
        @(negedge clk);
        check("fill_stall", bus.if_stall_o, 1);
        step();

        // Drain; full buffer refuses the concurrent fetch
        bus.rob_full_i = 0;
        for (int k = 0; k < 4; k++) begin
            bus.if_valid_i = (k == 0);
            bus.if_IR_i    = 32'h1FE;
            @(negedge clk);
            check("drain_ir", bus.id_IR_o, 64'h100 + k);
            check("drain_disp", bus.dispatch_en_o, 1);
            if (k == 0) check("drain_npc", bus.id_npc_o, 64'h1000);
            step();
        end
        bus.if_valid_i = 0;
        @(negedge clk);
        check("fill_5th_dropped", bus.id_valid_inst_o, 0);
`ifdef DISPATCH_PERF_EN
        check("perf_stall", perf_stall_cnt, 4);
        check("perf_disp", perf_disp_cnt, 4);
`endif
        step();

        // Streaming across pointer wrap
        for (int k = 0; k <= 12; k++) begin
            bus.if_valid_i = (k < 12);
            bus.if_IR_i    = 32'h200 + k;
            bus.if_npc_i   = 64'h2000 + 4 * k;
            @(negedge clk);
            if (k == 0) begin
                check("stream_first", bus.id_valid_inst_o, 0);
            end else begin
                check("stream_disp", bus.dispatch_en_o, 1);
                check("stream_ir", bus.id_IR_o, 64'h200 + k - 1);
                check("stream_nostall", bus.if_stall_o, 0);
            end
            step();
        end
        bus.if_valid_i = 0;
        @(negedge clk);
        check("stream_empty", bus.id_valid_inst_o, 0);
        step();

        // LSQ / RS gating
        bus.if_valid_i = 1; bus.if_IR_i = 32'h300;
        bus.id_rd_mem_i = 1; bus.lsq_full_i = 1;
        step();
        bus.if_valid_i = 0;
        @(negedge clk);
        check("lsq_valid", bus.id_valid_inst_o, 1);
        check("lsq_block", bus.dispatch_en_o, 0);
        bus.id_rd_mem_i = 0; bus.rs_full_i = 1;
        #1;
        check("rs_block", bus.dispatch_en_o, 0);
        bus.rs_full_i = 0;
        #1;
        check("lsq_pass", bus.dispatch_en_o, 1);
        step();
        bus.lsq_full_i = 0;
        @(negedge clk);
        check("lsq_empty", bus.id_valid_inst_o, 0);
        step();

        // Illegal halt pending, then recover
        bus.rob_full_i = 1;
        for (int k = 0; k < 4; k++) begin
            bus.if_valid_i = 1; bus.if_IR_i = 32'h500 + k;
            step();
        end
        bus.if_valid_i = 0; bus.rob_full_i = 0; bus.id_illegal_i = 1;
        @(negedge clk);
        check("illeg_disp", bus.dispatch_en_o, 1);
        step();
        bus.id_illegal_i = 0;
        @(negedge clk);
        check("hp_illegal", bus.illegal_o, 1);
        check("hp_stall", bus.if_stall_o, 1);
        check("hp_valid", bus.id_valid_inst_o, 0);
        step();
        bus.br_recover_i = 1; bus.if_valid_i = 1; bus.if_IR_i = 32'h5FF;
        bus.rob_halt_retired_i = 1;
        @(negedge clk);
        check("rec_nodisp", bus.dispatch_en_o, 0);
        step();
        bus.br_recover_i = 0; bus.if_valid_i = 0; bus.rob_halt_retired_i = 0;
        @(negedge clk);
        check("rec_illegal", bus.illegal_o, 0);
        check("rec_halted", bus.halted_o, 0);
        check("rec_stall", bus.if_stall_o, 0);
        check("rec_empty", bus.id_valid_inst_o, 0);
        step();
        bus.if_valid_i = 1; bus.if_IR_i = 32'h510;
        step();
        bus.if_valid_i = 0;
        @(negedge clk);
        check("rec_resume_ir", bus.id_IR_o, 64'h510);
        check("rec_resume_disp", bus.dispatch_en_o, 1);
        step();

        // Asynchronous reset mid-operation
        bus.rob_full_i = 1;
        bus.if_valid_i = 1; bus.if_IR_i = 32'h600; step();
        bus.if_IR_i = 32'h601; step();
        bus.if_valid_i = 0;
        @(negedge clk);
        check("prerst_valid", bus.id_valid_inst_o, 1);
        bus.rob_full_i = 0;
        #1;
        check("prerst_disp", bus.dispatch_en_o, 1);
        rst = 1'b0;
        #1;
        check("arst_stall", bus.if_stall_o, 0);
        check("arst_valid", bus.id_valid_inst_o, 0);
        check("arst_disp", bus.dispatch_en_o, 0);
        check("arst_halted", bus.halted_o, 0);
        check("arst_illeg", bus.illegal_o, 0);
`ifdef DISPATCH_PERF_EN
        check("arst_perf_stall", perf_stall_cnt, 0);
        check("arst_perf_disp", perf_disp_cnt, 0);
`endif
        step();
        rst = 1'b1;
        @(negedge clk);
        check("postrst_empty", bus.id_valid_inst_o, 0);
        step();

        // Halt to terminal HALTED
        bus.if_valid_i = 1; bus.if_IR_i = 32'h700;
        step();
        bus.if_IR_i = 32'h701; bus.id_halt_i = 1;
        @(negedge clk);
        check("halt_disp", bus.dispatch_en_o, 1);
        check("halt_ir", bus.id_IR_o, 64'h700);
        step();
        bus.if_IR_i = 32'h702; bus.id_halt_i = 0;
        @(negedge clk);
        check("halt_stall", bus.if_stall_o, 1);
        check("halt_valid", bus.id_valid_inst_o, 0);
        check("halt_nodisp", bus.dispatch_en_o, 0);
        check("halt_notyet", bus.halted_o, 0);
        step();
        bus.if_valid_i = 0; bus.rob_halt_retired_i = 1;
        @(negedge clk);
        check("retire_pend", bus.halted_o, 0);
        step();
        bus.rob_halt_retired_i = 0;
        @(negedge clk);
        check("halted", bus.halted_o, 1);
        check("halted_stall", bus.if_stall_o, 1);
        check("halted_illeg", bus.illegal_o, 0);
        step();
        bus.br_recover_i = 1;
        step();
        bus.br_recover_i = 0;
        @(negedge clk);
        check("halted_sticky", bus.halted_o, 1);
        check("halted_novalid", bus.id_valid_inst_o, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
